// File: rtl/pkt_hdr_serializer.sv
// Header serializer: pops one header from the switch output FIFO into a
// shadow buffer and streams it to the egress MAC as fixed-width beats on a
// valid/ready interface. Only one header is in flight at a time. The block
// also counts the headers that have been fully sent.
module pkt_hdr_serializer #(
  parameter int HDR_LEN    = 64,
  parameter int BEAT_BYTES = 8
) (
  input  logic                          clk,
  input  logic                          rst,            // async, active-low
  input  logic                          sw_out_empty_i,
  output logic                          sw_rd_o,
  input  logic [HDR_LEN-1:0][7:0]       sw_pkt_hdr_i,   // byte [0] goes first on the wire
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [BEAT_BYTES*8-1:0]       m_data_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic [31:0]                   pkt_cnt_o
);

  localparam int NBEATS = HDR_LEN / BEAT_BYTES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [BW-1:0]                 r_beat;
  logic [HDR_LEN-1:0][7:0]       r_buf;
  logic [31:0]                   r_pkt_cnt;

  // The buffer seen as NBEATS groups of BEAT_BYTES bytes. Byte i of the
  // header sits at beat i/BEAT_BYTES, slot i%BEAT_BYTES.
  logic [NBEATS-1:0][BEAT_BYTES-1:0][7:0] w_beats;
  logic [BEAT_BYTES-1:0][7:0]             w_cur;
  logic [BEAT_BYTES*8-1:0]                w_data;
  logic                                   w_last;
  logic                                   w_accept;

  assign w_beats  = r_buf;
  assign w_cur    = w_beats[r_beat];
  assign w_last   = (r_beat == BW'(NBEATS - 1));
  assign w_accept = (r_state == S_SEND) && m_ready_i;

  // The lowest-index byte of the beat goes to the most significant lane.
  generate
    for (genvar gi = 0; gi < BEAT_BYTES; gi++) begin : g_lane
      assign w_data[BEAT_BYTES*8-1-8*gi -: 8] = w_cur[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic and outputs decoded from the state. Data and last are
  // forced to zero outside SEND.
  always_comb begin
    w_state_next = r_state;
    sw_rd_o      = 1'b0;
    m_valid_o    = 1'b0;
    m_data_o     = '0;
    m_last_o     = 1'b0;
    busy_o       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (!sw_out_empty_i) w_state_next = S_READ;
      end
      S_READ: begin
        sw_rd_o      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        w_state_next = S_SEND;
      end
      S_SEND: begin
        m_valid_o = 1'b1;
        m_data_o  = w_data;
        m_last_o  = w_last;
        if (m_ready_i && w_last) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the FIFO head one cycle after the pop, then step through the beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf  <= '0;
      r_beat <= '0;
    end else if (r_state == S_WAIT) begin
      r_buf  <= sw_pkt_hdr_i;
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat <= w_last ? '0 : r_beat + BW'(1);
    end
  end

  // Count headers whose final beat was accepted. The counter wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_pkt_cnt <= '0;
    else if (w_accept && w_last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
  end

  assign pkt_cnt_o = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_hdr_serializer.sv
// Directed bench for pkt_hdr_serializer: reset, single header, back-pressure,
// back-to-back headers, mid-send reset and counter wrap.
module tb_pkt_hdr_serializer;

  logic              clk;
  logic              rst;
  logic              sw_out_empty_i;
  logic              sw_rd_o;
  logic [63:0][7:0]  sw_pkt_hdr_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [63:0]       m_data_o;
  logic              m_last_o;
  logic              busy_o;
  logic [31:0]       pkt_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [63:0][7:0] hdr_a;
  logic [63:0][7:0] hdr_b;

  pkt_hdr_serializer #(.HDR_LEN(64), .BEAT_BYTES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_out_empty_i(sw_out_empty_i),
    .sw_rd_o       (sw_rd_o),
    .sw_pkt_hdr_i  (sw_pkt_hdr_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_last_o      (m_last_o),
    .busy_o        (busy_o),
    .pkt_cnt_o     (pkt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure pop spacing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected beat b of header e: byte 8b+k in lane k, lane 0 at the MSB.
  function automatic logic [63:0] exp_beat(input logic [63:0][7:0] e, input int b);
    logic [63:0] x;
    for (int k = 0; k < 8; k++) x[63-8*k -: 8] = e[b*8+k];
    return x;
  endfunction

  // Checks outputs while idle (nothing valid, data/last zero).
  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, {63'd0, m_valid_o}, 64'd0);
    chk({tag, "_last"},  {63'd0, m_last_o},  64'd0);
    chk({tag, "_data"},  m_data_o,           64'd0);
  endtask

  // Called at a negedge in IDLE: requests a header and walks through READ and
  // WAIT. Returns at the negedge where beat 0 is presented.
  task automatic start_hdr(input bit keep_empty_low, output int rd_cyc);
    sw_out_empty_i = 1'b0;
    @(negedge clk);
    chk("rd_pulse", {63'd0, sw_rd_o}, 64'd1);
    chk("rd_busy",  {63'd0, busy_o},  64'd1);
    chk_quiet("rd");
    rd_cyc = cyc;
    if (!keep_empty_low) sw_out_empty_i = 1'b1;
    @(negedge clk);
    chk("wait_rd",   {63'd0, sw_rd_o}, 64'd0);
    chk("wait_busy", {63'd0, busy_o},  64'd1);
    chk_quiet("wait");
    @(negedge clk);
  endtask

  // Called at the negedge where beat first_b is presented. Checks each beat,
  // optionally stalls on stall_b, and returns either at the negedge showing
  // stop_b (not accepted) or, for stop_b >= 8, at the IDLE negedge after the
  // last beat.
  task automatic run_beats(input logic [63:0][7:0] e, input int first_b,
                           input int stall_b, input int stall_n, input int stop_b);
    for (int b = first_b; b < 8; b++) begin
      if (b == stop_b) return;
      $display("beat %0d data=%h last=%0b", b, m_data_o, m_last_o);
      chk($sformatf("valid_b%0d", b), {63'd0, m_valid_o}, 64'd1);
      chk($sformatf("data_b%0d", b),  m_data_o, exp_beat(e, b));
      chk($sformatf("last_b%0d", b),  {63'd0, m_last_o}, {63'd0, b == 7});
      chk($sformatf("rd_b%0d", b),    {63'd0, sw_rd_o}, 64'd0);
      if (b == stall_b) begin
        m_ready_i = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          chk($sformatf("stall%0d_valid", s), {63'd0, m_valid_o}, 64'd1);
          chk($sformatf("stall%0d_data", s),  m_data_o, exp_beat(e, b));
          chk($sformatf("stall%0d_last", s),  {63'd0, m_last_o}, {63'd0, b == 7});
          chk($sformatf("stall%0d_rd", s),    {63'd0, sw_rd_o}, 64'd0);
        end
        m_ready_i = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int c0;
    int c1;

    for (int i = 0; i < 64; i++) begin
      hdr_a[i] = 8'(i);
      hdr_b[i] = 8'(i * 7 + 3);
    end
    {hdr_a[0], hdr_a[1], hdr_a[2], hdr_a[3], hdr_a[4], hdr_a[5], hdr_a[6], hdr_a[7]} =
      64'hc858c0b5fe1e9003;
    {hdr_a[8], hdr_a[9], hdr_a[10], hdr_a[11], hdr_a[12], hdr_a[13], hdr_a[14], hdr_a[15]} =
      64'h25b97f0608004500;

    // Test 1: reset held with a non-empty FIFO.
    rst            = 1'b0;
    sw_out_empty_i = 1'b0;
    m_ready_i      = 1'b1;
    sw_pkt_hdr_i   = hdr_a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rd",   {63'd0, sw_rd_o}, 64'd0);
      chk("rst_busy", {63'd0, busy_o},  64'd0);
      chk("rst_cnt",  {32'd0, pkt_cnt_o}, 64'd0);
      chk_quiet("rst");
    end

    // Test 2: release reset; pop follows in the next cycle, full-rate send.
    rst = 1'b1;
    start_hdr(1'b0, c0);
    chk("t2_beat0_lit", m_data_o, 64'hc858c0b5fe1e9003);
    run_beats(hdr_a, 0, -1, 0, 1);
    chk("t2_beat1_lit", m_data_o, 64'h25b97f0608004500);
    run_beats(hdr_a, 1, -1, 0, 8);
    chk("t2_idle_busy", {63'd0, busy_o}, 64'd0);
    chk_quiet("t2_idle");
    chk("t2_cnt", {32'd0, pkt_cnt_o}, 64'd1);
    $display("test2 header sent pkt_cnt=%0d", pkt_cnt_o);

    // Test 3: back-pressure for 5 cycles on beat 3.
    sw_pkt_hdr_i = hdr_b;
    start_hdr(1'b0, c0);
    run_beats(hdr_b, 0, 3, 5, 8);
    chk("t3_cnt", {32'd0, pkt_cnt_o}, 64'd2);
    chk_quiet("t3_idle");
    $display("test3 header sent pkt_cnt=%0d", pkt_cnt_o);

    // Test 4: two headers queued back to back.
    sw_pkt_hdr_i = hdr_a;
    start_hdr(1'b1, c0);
    sw_pkt_hdr_i = hdr_b;           // first header already captured
    run_beats(hdr_a, 0, -1, 0, 8);
    chk("t4_gap_rd",   {63'd0, sw_rd_o}, 64'd0);
    chk("t4_gap_busy", {63'd0, busy_o},  64'd0);
    chk("t4_cnt_mid",  {32'd0, pkt_cnt_o}, 64'd3);
    start_hdr(1'b0, c1);
    chk("t4_rd_spacing", 64'(c1 - c0), 64'd11);
    run_beats(hdr_b, 0, -1, 0, 8);
    chk("t4_cnt", {32'd0, pkt_cnt_o}, 64'd4);
    $display("test4 two headers sent pkt_cnt=%0d spacing=%0d", pkt_cnt_o, c1 - c0);

    // Test 5: asynchronous reset while beat 4 is on the bus.
    sw_pkt_hdr_i = hdr_b;
    start_hdr(1'b0, c0);
    run_beats(hdr_b, 0, -1, 0, 4);
    chk("t5_beat4", m_data_o, exp_beat(hdr_b, 4));
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_busy", {63'd0, busy_o},    64'd0);
    chk("t5_rst_rd",   {63'd0, sw_rd_o},   64'd0);
    chk("t5_rst_cnt",  {32'd0, pkt_cnt_o}, 64'd0);
    chk_quiet("t5_rst");
    @(negedge clk);
    rst          = 1'b1;
    sw_pkt_hdr_i = hdr_a;
    start_hdr(1'b0, c0);
    run_beats(hdr_a, 0, -1, 0, 8);
    chk("t5_cnt", {32'd0, pkt_cnt_o}, 64'd1);
    $display("test5 reset mid-send then fresh header pkt_cnt=%0d", pkt_cnt_o);

    // Test 6: counter wrap from all-ones.
    force dut.r_pkt_cnt = 32'hFFFF_FFFF;
    #1 release dut.r_pkt_cnt;
    #1 chk("t6_cnt_forced", {32'd0, pkt_cnt_o}, 64'hFFFF_FFFF);
    sw_pkt_hdr_i = hdr_b;
    start_hdr(1'b0, c0);
    run_beats(hdr_b, 0, -1, 0, 8);
    chk("t6_cnt_wrap", {32'd0, pkt_cnt_o}, 64'd0);
    $display("test6 wrap pkt_cnt=%0d", pkt_cnt_o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
